// File: rtl/mai_rd_arbiter_if.sv
// Read-path bundle between NM client masters, the arbiter and the downstream memory port.
// The arbiter uses the slave view; the surrounding clients and memory use the master view.
interface mai_rd_arbiter_if #(
    parameter int unsigned NM = 3,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned TW = 4,
    parameter int unsigned LW = 2,
    parameter int unsigned QW = 4
);
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

    // master-side request channel
    logic [NM-1:0]    m_valid_rd;
    logic [NM*AW-1:0] m_addr_rd;
    logic [NM*TW-1:0] m_tag_rd;
    logic [NM*LW-1:0] m_len_rd;
    logic [NM*QW-1:0] m_qos_rd;
    logic [NM-1:0]    m_ready_rd;

    // master-side response channel
    logic [NM-1:0]    m_valid_rsp;
    logic [TW-1:0]    m_tag_rsp;
    logic [DW-1:0]    m_data_rsp;
    logic [1:0]       m_status_rsp;
    logic             m_eod;
    logic [NM-1:0]    m_ready_rsp;

    // downstream request channel
    logic             s_valid_rd;
    logic [AW-1:0]    s_addr_rd;
    logic [IW+TW-1:0] s_tag_rd;
    logic [LW-1:0]    s_len_rd;
    logic [QW-1:0]    s_qos_rd;
    logic             s_ready_rd;

    // downstream response channel
    logic             s_valid_rsp;
    logic [IW+TW-1:0] s_tag_rsp;
    logic [DW-1:0]    s_data_rsp;
    logic [1:0]       s_status_rsp;
    logic             s_eod;
    logic             s_ready_rsp;

    modport slave (
        input  m_valid_rd, m_addr_rd, m_tag_rd, m_len_rd, m_qos_rd, m_ready_rsp,
               s_ready_rd, s_valid_rsp, s_tag_rsp, s_data_rsp, s_status_rsp, s_eod,
        output m_ready_rd, m_valid_rsp, m_tag_rsp, m_data_rsp, m_status_rsp, m_eod,
               s_valid_rd, s_addr_rd, s_tag_rd, s_len_rd, s_qos_rd, s_ready_rsp
    );

    modport master (
        output m_valid_rd, m_addr_rd, m_tag_rd, m_len_rd, m_qos_rd, m_ready_rsp,
               s_ready_rd, s_valid_rsp, s_tag_rsp, s_data_rsp, s_status_rsp, s_eod,
        input  m_ready_rd, m_valid_rsp, m_tag_rsp, m_data_rsp, m_status_rsp, m_eod,
               s_valid_rd, s_addr_rd, s_tag_rd, s_len_rd, s_qos_rd, s_ready_rsp
    );
endinterface

// File: rtl/mai_rd_arbiter.sv
// N-master read arbiter: QoS priority with round-robin tie-break and starvation aging,
// one-entry downstream request register, index-tagged combinational response steering.
module mai_rd_arbiter #(
    parameter int unsigned NM  = 3,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned TW  = 4,
    parameter int unsigned LW  = 2,
    parameter int unsigned QW  = 4,
    parameter int unsigned AGE = 15
) (
    input  logic              clk,
    input  logic              resetn,
    mai_rd_arbiter_if.slave   bus,
    output logic              err_bad_idx
);
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned GW = $clog2(AGE + 1);
    localparam logic [QW-1:0] QOS_MAX = '1;
    localparam logic [GW-1:0] AGE_MAX = GW'(AGE);

    logic [IW-1:0] rr_ptr;
    logic [GW-1:0] age [NM];

    logic          load_c;
    logic          any_c;
    logic          grant_c;
    logic [IW-1:0] win_idx;
    logic [QW-1:0] best_q;
    logic [IW-1:0] idx_c;
    logic          idx_ok_c;

    assign load_c  = !bus.s_valid_rd || bus.s_ready_rd;
    assign grant_c = resetn && load_c && any_c;

    // Scan from rr_ptr+1 with wrap; strict '>' keeps the first master found among equal QoS.
    always_comb begin : arb_search
        int            j;
        logic [IW-1:0] jj;
        logic [QW-1:0] eff;
        j       = 0;
        jj      = '0;
        eff     = '0;
        win_idx = rr_ptr;
        best_q  = '0;
        any_c   = 1'b0;
        for (int k = 1; k <= int'(NM); k++) begin
            j = int'(rr_ptr) + k;
            if (j >= int'(NM)) j = j - int'(NM);
            jj  = IW'(j);
            eff = (age[jj] == AGE_MAX) ? QOS_MAX : bus.m_qos_rd[jj*QW +: QW];
            if (bus.m_valid_rd[jj] && (!any_c || (eff > best_q))) begin
                any_c   = 1'b1;
                best_q  = eff;
                win_idx = jj;
            end
        end
    end

    always_comb begin : grant_decode
        bus.m_ready_rd = '0;
        if (grant_c) bus.m_ready_rd[win_idx] = 1'b1;
    end

    // Request register: load on grant, otherwise empty out once the downstream has taken it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.s_valid_rd <= 1'b0;
            bus.s_addr_rd  <= '0;
            bus.s_tag_rd   <= '0;
            bus.s_len_rd   <= '0;
            bus.s_qos_rd   <= '0;
            rr_ptr         <= IW'(NM - 1);
        end else if (grant_c) begin
            bus.s_valid_rd <= 1'b1;
            bus.s_addr_rd  <= bus.m_addr_rd[win_idx*AW +: AW];
            bus.s_tag_rd   <= {win_idx, bus.m_tag_rd[win_idx*TW +: TW]};
            bus.s_len_rd   <= bus.m_len_rd[win_idx*LW +: LW];
            bus.s_qos_rd   <= bus.m_qos_rd[win_idx*QW +: QW];
            rr_ptr         <= win_idx;
        end else if (load_c) begin
            bus.s_valid_rd <= 1'b0;
        end
    end

    // Per-master wait counters, saturating at AGE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NM); i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NM); i++) begin
                if (!bus.m_valid_rd[i] || bus.m_ready_rd[i]) age[i] <= '0;
                else if (age[i] != AGE_MAX)                  age[i] <= age[i] + 1'b1;
            end
        end
    end

    assign idx_c    = bus.s_tag_rsp[IW+TW-1:TW];
    assign idx_ok_c = ({1'b0, idx_c} < (IW+1)'(NM));

    // Response steering; beats carrying an out-of-range index are swallowed.
    always_comb begin : rsp_route
        bus.m_valid_rsp = '0;
        bus.s_ready_rsp = 1'b1;
        if (idx_ok_c) begin
            bus.m_valid_rsp[idx_c] = bus.s_valid_rsp && resetn;
            bus.s_ready_rsp        = bus.m_ready_rsp[idx_c];
        end
    end

    assign bus.m_tag_rsp    = bus.s_tag_rsp[TW-1:0];
    assign bus.m_data_rsp   = bus.s_data_rsp;
    assign bus.m_status_rsp = bus.s_status_rsp;
    assign bus.m_eod        = bus.s_eod;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                            err_bad_idx <= 1'b0;
        else if (bus.s_valid_rsp && !idx_ok_c)  err_bad_idx <= 1'b1;
    end
endmodule

// File: tb/tb_mai_rd_arbiter.sv
// Directed self-checking bench for mai_rd_arbiter (NM=3): grant order, aging, stall,
// response steering and reset behaviour against hand-computed values.
module tb_mai_rd_arbiter;
    logic clk;
    logic resetn;
    logic err_bad_idx;
    int   n_checks;
    int   n_fail;

    mai_rd_arbiter_if #(.NM(3), .AW(32), .DW(32), .TW(4), .LW(2), .QW(4)) bus ();

    mai_rd_arbiter #(.NM(3), .AW(32), .DW(32), .TW(4), .LW(2), .QW(4), .AGE(15)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .err_bad_idx (err_bad_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        bus.m_valid_rd   = '0;
        bus.m_addr_rd    = '0;
        bus.m_tag_rd     = '0;
        bus.m_len_rd     = '0;
        bus.m_qos_rd     = '0;
        bus.m_ready_rsp  = '0;
        bus.s_ready_rd   = 1'b0;
        bus.s_valid_rsp  = 1'b0;
        bus.s_tag_rsp    = '0;
        bus.s_data_rsp   = '0;
        bus.s_status_rsp = '0;
        bus.s_eod        = 1'b0;

        // reset state, with requests and a response presented during reset
        bus.m_valid_rd  = 3'b111;
        bus.s_valid_rsp = 1'b1;
        #3;
        check("rst_m_ready", 64'(bus.m_ready_rd), 64'h0);
        check("rst_m_valid_rsp", 64'(bus.m_valid_rsp), 64'h0);
        step();
        check("rst_s_valid", 64'(bus.s_valid_rd), 64'h0);
        check("rst_s_addr", 64'(bus.s_addr_rd), 64'h0);
        check("rst_s_tag", 64'(bus.s_tag_rd), 64'h0);
        check("rst_err", 64'(err_bad_idx), 64'h0);
        bus.m_valid_rd  = '0;
        bus.s_valid_rsp = 1'b0;
        resetn = 1'b1;
        step();

        // single request from master 1
        bus.m_addr_rd[32 +: 32] = 32'h1000;
        bus.m_tag_rd[4 +: 4]    = 4'd5;
        bus.m_len_rd[2 +: 2]    = 2'd3;
        bus.m_qos_rd[4 +: 4]    = 4'd2;
        bus.m_valid_rd          = 3'b010;
        bus.s_ready_rd          = 1'b1;
        #1;
        check("single_grant", 64'(bus.m_ready_rd), 64'h2);
        step();
        bus.m_valid_rd = '0;
        check("single_s_valid", 64'(bus.s_valid_rd), 64'h1);
        check("single_s_addr", 64'(bus.s_addr_rd), 64'h1000);
        check("single_s_tag", 64'(bus.s_tag_rd), 64'h15);
        check("single_s_len", 64'(bus.s_len_rd), 64'h3);
        check("single_s_qos", 64'(bus.s_qos_rd), 64'h2);
        step();
        check("single_drain", 64'(bus.s_valid_rd), 64'h0);

        // reset pulse while a request is held downstream
        bus.s_ready_rd = 1'b0;
        bus.m_valid_rd = 3'b010;
        step();
        bus.m_valid_rd = 3'b001;
        check("hold_s_valid", 64'(bus.s_valid_rd), 64'h1);
        #1;
        check("hold_no_grant", 64'(bus.m_ready_rd), 64'h0);
        #2;
        resetn = 1'b0;
        #1;
        check("rstpulse_s_valid", 64'(bus.s_valid_rd), 64'h0);
        check("rstpulse_s_addr", 64'(bus.s_addr_rd), 64'h0);
        check("rstpulse_m_ready", 64'(bus.m_ready_rd), 64'h0);
        bus.m_valid_rd = '0;
        #1;
        resetn = 1'b1;
        step();

        // equal QoS round robin, starting from master 0 after reset
        for (int i = 0; i < 3; i++) begin
            bus.m_addr_rd[i*32 +: 32] = 32'h100 * (i + 1);
            bus.m_tag_rd[i*4 +: 4]    = 4'(i + 8);
            bus.m_qos_rd[i*4 +: 4]    = 4'd3;
        end
        bus.m_valid_rd = 3'b111;
        bus.s_ready_rd = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1;
            check("rr_grant", 64'(bus.m_ready_rd), 64'(1 << (g % 3)));
            step();
            check("rr_s_idx", 64'(bus.s_tag_rd[5:4]), 64'(g % 3));
        end
        bus.m_valid_rd = '0;
        step();

        // starvation: master 0 (qos 1) loses to master 2 (qos 15) until its age reaches 15
        bus.m_qos_rd[0 +: 4] = 4'd1;
        bus.m_qos_rd[8 +: 4] = 4'd15;
        bus.m_valid_rd       = 3'b101;
        for (int c = 0; c < 16; c++) begin
            #1;
            check("age_grant", 64'(bus.m_ready_rd), (c == 15) ? 64'h1 : 64'h4);
            step();
        end
        bus.m_valid_rd = '0;
        check("age_s_idx", 64'(bus.s_tag_rd[5:4]), 64'h0);
        check("age_s_qos", 64'(bus.s_qos_rd), 64'h1);
        step();

        // downstream stall: held request stays stable, no grants
        bus.m_addr_rd[0 +: 32]  = 32'hA0;
        bus.m_addr_rd[32 +: 32] = 32'hB0;
        bus.m_qos_rd[0 +: 4]    = 4'd3;
        bus.m_qos_rd[4 +: 4]    = 4'd3;
        bus.m_valid_rd          = 3'b011;
        bus.s_ready_rd          = 1'b0;
        #1;
        check("stall_first_grant", 64'(bus.m_ready_rd), 64'h2);
        step();
        bus.m_valid_rd = 3'b001;
        for (int s = 0; s < 4; s++) begin
            #1;
            check("stall_m_ready", 64'(bus.m_ready_rd), 64'h0);
            check("stall_s_valid", 64'(bus.s_valid_rd), 64'h1);
            check("stall_s_addr", 64'(bus.s_addr_rd), 64'hB0);
            step();
        end
        bus.s_ready_rd = 1'b1;
        #1;
        check("b2b_grant", 64'(bus.m_ready_rd), 64'h1);
        step();
        bus.m_valid_rd = '0;
        check("b2b_s_addr", 64'(bus.s_addr_rd), 64'hA0);
        check("b2b_s_tag", 64'(bus.s_tag_rd), 64'h08);
        step();
        check("b2b_drain", 64'(bus.s_valid_rd), 64'h0);

        // response routed to master 2
        bus.s_valid_rsp  = 1'b1;
        bus.s_tag_rsp    = 6'b10_1001;
        bus.s_data_rsp   = 32'hDEADBEEF;
        bus.s_status_rsp = 2'b10;
        bus.s_eod        = 1'b1;
        bus.m_ready_rsp  = 3'b000;
        #1;
        check("rsp_valid", 64'(bus.m_valid_rsp), 64'h4);
        check("rsp_s_ready_lo", 64'(bus.s_ready_rsp), 64'h0);
        check("rsp_tag", 64'(bus.m_tag_rsp), 64'h9);
        check("rsp_data", 64'(bus.m_data_rsp), 64'hDEADBEEF);
        check("rsp_status", 64'(bus.m_status_rsp), 64'h2);
        check("rsp_eod", 64'(bus.m_eod), 64'h1);
        bus.m_ready_rsp = 3'b011;
        #1;
        check("rsp_s_ready_other", 64'(bus.s_ready_rsp), 64'h0);
        bus.m_ready_rsp = 3'b100;
        #1;
        check("rsp_s_ready_hi", 64'(bus.s_ready_rsp), 64'h1);
        step();
        check("rsp_err_clean", 64'(err_bad_idx), 64'h0);

        // bad index 3: dropped, sticky error
        bus.s_tag_rsp   = 6'b11_1001;
        bus.m_ready_rsp = 3'b000;
        #1;
        check("bad_m_valid", 64'(bus.m_valid_rsp), 64'h0);
        check("bad_s_ready", 64'(bus.s_ready_rsp), 64'h1);
        step();
        check("bad_err_set", 64'(err_bad_idx), 64'h1);
        bus.s_tag_rsp = 6'b00_0001;
        #1;
        check("rsp0_valid", 64'(bus.m_valid_rsp), 64'h1);
        check("rsp0_s_ready", 64'(bus.s_ready_rsp), 64'h0);
        step();
        check("bad_err_sticky", 64'(err_bad_idx), 64'h1);
        bus.s_valid_rsp = 1'b0;
        resetn = 1'b0;
        #1;
        check("err_cleared", 64'(err_bad_idx), 64'h0);
        #1;
        resetn = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mai_rd_arbiter.md
# mai_rd_arbiter

Parametrised N-master read-path interconnector for the memory access subsystem. It arbitrates read requests from NM masters (IF, DM, MAC and future clients) onto one downstream read port using QoS priority with round-robin tie-break and starvation aging. It tags each forwarded request with the master index and steers read responses back to the originating master. It sits between the client fetch/load units and the memory access controller.

## Interface
- NM, 3: number of masters (≥2)
- AW, 32: address width
- DW, 32: data width
- TW, 4: master tag width
- LW, 2: burst length field width
- QW, 4: QoS width, larger value = higher priority
- AGE, 15: wait cycles before a pending request is promoted to QoS all-ones
- IW is derived as clog2(NM): the master index width (2 for NM=3)

Ports (master i occupies slice [i*X +: X] of packed buses):
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- m_valid_rd  in  NM  request valid per master
- m_addr_rd  in  NM*AW  request address
- m_tag_rd  in  NM*TW  request tag
- m_len_rd  in  NM*LW  burst length
- m_qos_rd  in  NM*QW  request QoS
- m_ready_rd  out  NM  request accepted, at most one-hot
- m_valid_rsp  out  NM  response valid, at most one-hot
- m_tag_rsp  out  TW  shared response tag
- m_data_rsp  out  DW  shared response data
- m_status_rsp  out  2  shared response status
- m_eod  out  1  last beat of response
- m_ready_rsp  in  NM  master can take response
- s_valid_rd  out  1  downstream request valid
- s_addr_rd  out  AW; s_tag_rd  out  IW+TW {index,tag}; s_len_rd  out  LW; s_qos_rd  out  QW
- s_ready_rd  in  1  downstream accepts request
- s_valid_rsp  in  1; s_tag_rsp  in  IW+TW; s_data_rsp  in  DW; s_status_rsp  in  2; s_eod  in  1
- s_ready_rsp  out  1  response accepted
- err_bad_idx  out  1  sticky: response arrived with index ≥ NM

## Operation
- One-entry output request register (s_*) loads when it is empty or when s_valid_rd && s_ready_rd in the same cycle.
- On a load cycle with any m_valid_rd set, exactly one winner i gets m_ready_rd[i]=1 combinationally. Its payload is registered with s_tag_rd={i, tag} and original QoS.
- m_ready_rd is all-zero when the register cannot load or resetn is low.
- Effective QoS: all-ones if age[i]==AGE, otherwise m_qos_rd[i]. The highest effective QoS wins. Ties are searched from rr_ptr+1 upward with wrap, and rr_ptr updates to the winner.
- age[i] increments, saturating at AGE, while m_valid_rd[i] && !m_ready_rd[i]. It clears when master i is granted or m_valid_rd[i] is low.
- Masters must hold valid and payload until ready. The block holds s_* stable while s_valid_rd && !s_ready_rd.
- Response path is combinational: idx = s_tag_rsp[IW+TW-1:TW].
  - If idx < NM: m_valid_rsp[idx]=s_valid_rsp, and s_ready_rsp=m_ready_rsp[idx].
  - m_tag_rsp is s_tag_rsp[TW-1:0]. Data, status and eod pass through.
  - If idx ≥ NM: m_valid_rsp=0 and s_ready_rsp=1, so the beat is dropped. err_bad_idx sets on s_valid_rsp and holds until reset.

## Timing
- Reset values:
  - s_valid_rd=0; s_addr_rd, s_tag_rd, s_len_rd, s_qos_rd = 0.
  - rr_ptr=NM-1, so master 0 wins the first tie.
  - All age counters 0; err_bad_idx=0.
  - m_ready_rd=0 and m_valid_rsp=0 while resetn is low.
- Request latency: a grant in cycle T gives s_valid_rd=1 in T+1. Sustained throughput is 1 request/cycle when s_ready_rd is held high.
- Back-to-back: downstream accept and a new grant occur in the same cycle.
- Response latency is 0 cycles, with no buffering.
- Asserting reset mid-request discards the held request immediately and asynchronously.
- A starved request is granted at most AGE+NM cycles after it becomes pending, provided the downstream accepts every cycle.

## Test plan
- Single request: master 1 presents addr 0x1000, tag 5, qos 2 with s_ready_rd=1 -> m_ready_rd=3'b010 in T; in T+1 s_valid_rd=1, s_addr_rd=0x1000, s_tag_rd=6'b01_0101.
- Equal QoS 3, all three masters valid continuously -> grants are 0,1,2,0,1,2 on consecutive cycles.
- Master 2 at qos 15 held valid, master 0 at qos 1 held valid -> master 2 is granted each cycle. Master 0 reaches age 15, ties at 15, and is granted within 17 cycles.
- s_ready_rd=0 for 4 cycles with s_valid_rd=1 -> s_* are stable, m_ready_rd=0 throughout, and age counters advance.
- Response with s_tag_rsp={2'd2,4'd9}, data 0xDEADBEEF, m_ready_rsp[2]=0 then 1 -> m_valid_rsp=3'b100 and s_ready_rsp follows m_ready_rsp[2]. Response index 3 -> dropped, s_ready_rsp=1, err_bad_idx=1 until reset.
- resetn pulsed low while s_valid_rd=1 -> s_valid_rd=0 immediately, and the next tie goes to master 0.
